// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier round-robin scheduler: pipeline depth,
// id sizing and the tag that travels alongside each in-flight product.
package mul_sched_pkg;

  localparam int MUL_LATENCY = 3;
  localparam int MAX_REQ     = 16;
  localparam int TAG_ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or after
// ptr, wrapping, and returns it both one-hot and as an index.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               hold,
  input  logic               rst,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic            found;
  logic [ID_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    if (!hold && !rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        sel = ID_W'((int'(ptr) + off) % NUM_REQ);
        if (!found && req[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          grant_idx  = sel;
        end
      end
    end
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one external pipelined multiplier among NUM_REQ requesters; a tag
// pipeline matched to the multiplier depth routes each product back to its owner.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       mul_rst_n,
  output logic                       mul_valid_in,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_valid_out,
  input  logic [2*WIDTH-1:0]         mul_p,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_p,
  output logic                       busy,
  output logic                       err
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr;
  tag_t               tags [LATENCY];
  tag_t               tail;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .hold      (hold),
    .rst       (rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready    = grant;
  assign mul_valid_in = |grant;
  assign mul_rst_n    = ~rst;
  assign mul_a        = mul_valid_in ? req_a[int'(grant_idx)*WIDTH +: WIDTH] : '0;
  assign mul_b        = mul_valid_in ? req_b[int'(grant_idx)*WIDTH +: WIDTH] : '0;
  assign tail         = tags[LATENCY-1];

  // A tail tag and the multiplier's valid must agree; any disagreement is
  // latched as an error and suppresses the response for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      err       <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: mul_valid_in, id: TAG_ID_W'(grant_idx)};
      for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
      if (mul_valid_in)
        ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        rsp_valid[i] <= tail.valid && mul_valid_out && (tail.id == TAG_ID_W'(i));
      if (tail.valid && mul_valid_out) begin
        rsp_id <= ID_W'(tail.id);
        rsp_p  <= mul_p;
      end
      if (tail.valid != mul_valid_out) err <= 1'b1;
    end
  end

  always_comb begin
    busy = |rsp_valid;
    for (int i = 0; i < LATENCY; i++) busy = busy | tags[i].valid;
  end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed and randomised checks of the round-robin multiplier scheduler with a
// behavioural 3-stage signed multiplier standing in for the shared instance.
module tb_mul_rr_scheduler;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hold = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             mul_rst_n;
  logic             mul_valid_in;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_valid_out;
  logic [2*W-1:0]   mul_p;
  logic [N-1:0]     rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_p;
  logic             busy;
  logic             err;

  logic             force_vo = 1'b0;
  logic [2:0]       pv = '0;
  logic [2*W-1:0]   pp [3] = '{default: '0};

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int     due;
    int     id;
    longint p;
  } exp_t;

  mul_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .LATENCY(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .mul_rst_n     (mul_rst_n),
    .mul_valid_in  (mul_valid_in),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_out (mul_valid_out),
    .mul_p         (mul_p),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_p         (rsp_p),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared multiplier, reset through mul_rst_n.
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      pv <= '0;
      for (int i = 0; i < 3; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[1:0], mul_valid_in};
      pp[0] <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
      pp[1] <= pp[0];
      pp[2] <= pp[1];
    end
  end

  assign mul_valid_out = pv[2] | force_vo;
  assign mul_p         = pp[2];

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]   = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    hold = 1'b0;
    force_vo = 1'b0;
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (req_ready !== 4'b0000 || mul_valid_in !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_grant: got ready=%b vin=%b expected 0000/0", req_ready, mul_valid_in);
    end
    tests_run++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mul_ops: got a=%0d b=%0d expected 0/0", mul_a, mul_b);
    end
    tests_run++;
    if (mul_rst_n !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mul_rst_n: got %b expected 0", mul_rst_n);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000 || rsp_id !== 2'd0 || rsp_p !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got v=%b id=%0d p=%0d expected 0/0/0", rsp_valid, rsp_id, rsp_p);
    end
    tests_run++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy_err: got busy=%b err=%b expected 0/0", busy, err);
    end
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    #1;
    tests_run++;
    if (mul_rst_n !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset: got rst_n=%b err=%b busy=%b expected 1/0/0", mul_rst_n, err, busy);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] exp_v;
    do_reset();
    @(negedge clk);
    set_req(0, 32'd100, 32'd200);
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got %b expected 0001", req_ready);
    end
    tests_run++;
    if (mul_valid_in !== 1'b1 || mul_a !== 32'd100 || mul_b !== 32'd200) begin
      tests_failed++;
      $display("[TB] FAIL single_issue: got vin=%b a=%0d b=%0d expected 1/100/200", mul_valid_in, mul_a, mul_b);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) clear_reqs();
      #1;
      exp_v = (k == 4) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (rsp_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL single_rsp_valid T+%0d: got %b expected %b", k, rsp_valid, exp_v);
      end
      if (k == 4) begin
        tests_run++;
        if (rsp_p !== 64'd20000 || rsp_id !== 2'd0) begin
          tests_failed++;
          $display("[TB] FAIL single_rsp_data: got p=%0d id=%0d expected 20000/0", $signed(rsp_p), rsp_id);
        end
      end
      if (k == 5) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL single_busy_idle: got %b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_v;
    longint       ep;
    int           g;
    do_reset();
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j == 0) for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(-10));
      if (j == 8) clear_reqs();
      #1;
      if (j < 8) begin
        tests_run++;
        if (req_ready !== 4'(1 << (j % 4)) || mul_a !== 32'(j % 4 + 1)) begin
          tests_failed++;
          $display("[TB] FAIL rr_grant cyc %0d: got ready=%b a=%0d expected %b/%0d", j, req_ready, mul_a, 4'(1 << (j % 4)), j % 4 + 1);
        end
      end
      g     = (j - 4) % 4;
      exp_v = (j >= 4 && j < 12) ? 4'(1 << g) : 4'b0000;
      tests_run++;
      if (rsp_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL rr_rsp_valid cyc %0d: got %b expected %b", j, rsp_valid, exp_v);
      end
      if (j >= 4 && j < 12) begin
        ep = -10 * (g + 1);
        tests_run++;
        if (rsp_p !== 64'(ep) || rsp_id !== 2'(g)) begin
          tests_failed++;
          $display("[TB] FAIL rr_rsp_data cyc %0d: got p=%0d id=%0d expected %0d/%0d", j, $signed(rsp_p), rsp_id, ep, g);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    longint ep;
    do_reset();
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      if (j == 0) set_req(2, 32'h8000_0000, 32'd1);
      if (j == 1) set_req(2, 32'h7FFF_FFFF, 32'd2);
      if (j == 2) clear_reqs();
      #1;
      if (j < 2) begin
        tests_run++;
        if (req_ready !== 4'b0100) begin
          tests_failed++;
          $display("[TB] FAIL b2b_grant cyc %0d: got %b expected 0100", j, req_ready);
        end
      end
      if (j == 4 || j == 5) begin
        ep = (j == 4) ? -64'sd2147483648 : 64'sd4294967294;
        tests_run++;
        if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_p !== 64'(ep)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_rsp cyc %0d: got v=%b id=%0d p=%0d expected 0100/2/%0d", j, rsp_valid, rsp_id, $signed(rsp_p), ep);
        end
      end
      if (j == 6) begin
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL b2b_rsp_end: got %b expected 0000", rsp_valid);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] exp_v;
    do_reset();
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd3);
      if (j == 2) hold = 1'b1;
      if (j == 8) hold = 1'b0;
      #1;
      if (j < 2) begin
        tests_run++;
        if (req_ready !== 4'(1 << j)) begin
          tests_failed++;
          $display("[TB] FAIL hold_pre_grant cyc %0d: got %b expected %b", j, req_ready, 4'(1 << j));
        end
      end else if (j < 8) begin
        tests_run++;
        if (req_ready !== 4'b0000 || mul_valid_in !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL hold_blocked cyc %0d: got ready=%b vin=%b expected 0000/0", j, req_ready, mul_valid_in);
        end
        exp_v = (j == 4) ? 4'b0001 : (j == 5) ? 4'b0010 : 4'b0000;
        tests_run++;
        if (rsp_valid !== exp_v) begin
          tests_failed++;
          $display("[TB] FAIL hold_drain cyc %0d: got %b expected %b", j, rsp_valid, exp_v);
        end
        if (j == 4 || j == 5) begin
          tests_run++;
          if (rsp_p !== 64'(3 * (j - 3))) begin
            tests_failed++;
            $display("[TB] FAIL hold_rsp_p cyc %0d: got %0d expected %0d", j, $signed(rsp_p), 3 * (j - 3));
          end
        end
        if (j == 5 || j == 6) begin
          tests_run++;
          if (busy !== (j == 5)) begin
            tests_failed++;
            $display("[TB] FAIL hold_busy cyc %0d: got %b expected %b", j, busy, j == 5);
          end
        end
      end else begin
        tests_run++;
        if (req_ready !== 4'b0100) begin
          tests_failed++;
          $display("[TB] FAIL hold_resume_ptr: got %b expected 0100", req_ready);
        end
      end
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j <= 14; j++) begin
      @(negedge clk);
      clear_reqs();
      if (j == 0) set_req(0, 32'd5, 32'd6);
      if (j == 1) set_req(1, 32'd7, 32'd8);
      if (j == 2) begin
        set_req(0, 32'd5, 32'd6);
        rst = 1'b1;
      end
      if (j == 3) rst = 1'b0;
      if (j == 9) set_req(3, 32'd9, 32'(-9));
      #1;
      if (j < 2) begin
        tests_run++;
        if (req_ready !== 4'(1 << j)) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_issue cyc %0d: got %b expected %b", j, req_ready, 4'(1 << j));
        end
      end
      if (j == 2) begin
        tests_run++;
        if (req_ready !== 4'b0000 || mul_rst_n !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_in_reset: got ready=%b rst_n=%b expected 0000/0", req_ready, mul_rst_n);
        end
      end
      if (j == 3) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_busy: got %b expected 0", busy);
        end
      end
      if (j >= 3 && j <= 8) begin
        tests_run++;
        if (rsp_valid !== 4'b0000 || err !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_quiet cyc %0d: got v=%b err=%b expected 0000/0", j, rsp_valid, err);
        end
      end
      if (j == 9) begin
        tests_run++;
        if (req_ready !== 4'b1000) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_reissue: got %b expected 1000", req_ready);
        end
      end
      if (j == 13) begin
        tests_run++;
        if (rsp_valid !== 4'b1000 || rsp_id !== 2'd3 || rsp_p !== 64'(-81)) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_rsp: got v=%b id=%0d p=%0d expected 1000/3/-81", rsp_valid, rsp_id, $signed(rsp_p));
        end
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk);
    force_vo = 1'b1;
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_before: got %b expected 0", err);
    end
    @(negedge clk);
    force_vo = 1'b0;
    #1;
    tests_run++;
    if (err !== 1'b1 || rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL err_set: got err=%b v=%b expected 1/0000", err, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: got %b expected 1", err);
    end
    do_reset();
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_cleared: got %b expected 0", err);
    end
  endtask

  task automatic test_random();
    exp_t          exp_q [$];
    exp_t          e;
    int            ptr_m;
    int            gi;
    bit            found;
    logic [N-1:0]  exp_g;
    do_reset();
    ptr_m = 0;
    for (int c = 0; c < 10006; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == c) begin
        e = exp_q.pop_front();
        tests_run++;
        if (rsp_valid !== 4'(1 << e.id) || rsp_id !== 2'(e.id) || rsp_p !== 64'(e.p)) begin
          tests_failed++;
          $display("[TB] FAIL rand_rsp cyc %0d: got v=%b id=%0d p=%0d expected %b/%0d/%0d", c, rsp_valid, rsp_id, $signed(rsp_p), 4'(1 << e.id), e.id, e.p);
        end
      end else begin
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL rand_no_rsp cyc %0d: got %b expected 0000", c, rsp_valid);
        end
      end
      if (c < 10000) begin
        req_valid = 4'($urandom_range(0, 15));
        hold      = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < N; i++) begin
          req_a[i*W +: W] = $urandom();
          req_b[i*W +: W] = $urandom();
        end
      end else begin
        clear_reqs();
        hold = 1'b0;
      end
      #1;
      found = 1'b0;
      gi    = 0;
      exp_g = '0;
      if (!hold) begin
        for (int off = 0; off < N; off++) begin
          if (!found && req_valid[(ptr_m + off) % N]) begin
            found = 1'b1;
            gi    = (ptr_m + off) % N;
          end
        end
      end
      if (found) exp_g[gi] = 1'b1;
      tests_run++;
      if (req_ready !== exp_g) begin
        tests_failed++;
        $display("[TB] FAIL rand_grant cyc %0d: got %b expected %b", c, req_ready, exp_g);
      end
      if (found) begin
        e.due = c + 4;
        e.id  = gi;
        e.p   = longint'($signed(req_a[gi*W +: W])) * longint'($signed(req_b[gi*W +: W]));
        exp_q.push_back(e);
        ptr_m = (gi + 1) % N;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
